// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host-side blocks: FSM encoding, 50 MHz timing
// defaults and the frame parity helper.
package ps2_pkg;

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] REQ      = 4'd1;
    localparam logic [3:0] REQ_D    = 4'd2;
    localparam logic [3:0] START    = 4'd3;
    localparam logic [3:0] DATA     = 4'd4;
    localparam logic [3:0] STOP     = 4'd5;
    localparam logic [3:0] ACK      = 4'd6;
    localparam logic [3:0] WAIT_REL = 4'd7;
    localparam logic [3:0] DONE     = 4'd8;

    localparam int RTS_CYCLES_DEF     = 5000;
    localparam int SETUP_CYCLES_DEF   = 100;
    localparam int TIMEOUT_CYCLES_DEF = 750000;
    localparam int FILTER_LEN_DEF     = 8;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the device-driven ps2c line; the output only changes after
// FILTER_LEN identical samples, and fall_tick_o marks each filtered 1->0 edge.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_i,
    output logic filt_o,
    output logic fall_tick_o
);

    logic [FILTER_LEN-1:0] sr_q, sr_d;
    logic                  filt_q, filt_d;

    always_comb begin
        sr_d   = {sr_q[FILTER_LEN-2:0], ps2c_i};
        filt_d = filt_q;
        if (&sr_q)
            filt_d = 1'b1;
        else if (~|sr_q)
            filt_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q   <= '0;
            filt_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o      = filt_q;
    assign fall_tick_o = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter. Drives only open-drain low enables;
// the device supplies the clock once the host releases ps2c.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int SETUP_CYCLES   = SETUP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int MAX_A = (RTS_CYCLES > SETUP_CYCLES) ? RTS_CYCLES : SETUP_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] RTS_LAST   = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       n_q, n_d;
    logic             bit_q, bit_d;
    logic             err_q, err_d;
    logic [8:0]       frame_q, frame_d;
    logic             filt, fall_tick;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk        (clk),
        .reset      (reset),
        .ps2c_i     (ps2c_in),
        .filt_o     (filt),
        .fall_tick_o(fall_tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        bit_d   = bit_q;
        err_d   = err_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr_ps2) begin
                    frame_d = {odd_parity(din), din};
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cnt_q == RTS_LAST) begin
                    cnt_d   = '0;
                    state_d = REQ_D;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ_D: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            START, DATA, STOP, ACK, WAIT_REL: begin
                // Same counter doubles as the inter-edge watchdog once the device owns the clock.
                cnt_d = fall_tick ? '0 : cnt_q + CNT_W'(1);
                if (!fall_tick && cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    case (state_q)
                        START: if (fall_tick) begin
                            bit_d   = frame_q[0];
                            n_d     = 4'd0;
                            state_d = DATA;
                        end
                        DATA: if (fall_tick) begin
                            bit_d = frame_q[n_q + 4'd1];
                            n_d   = n_q + 4'd1;
                            if (n_q == 4'd7)
                                state_d = STOP;
                        end
                        STOP: if (fall_tick) begin
                            bit_d   = 1'b1;
                            state_d = ACK;
                        end
                        ACK: if (fall_tick) begin
                            err_d   = ps2d_in;
                            state_d = WAIT_REL;
                        end
                        default: if (filt && ps2d_in)
                            state_d = DONE;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= 4'd0;
            bit_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign ps2c_oe      = (state_q == REQ) || (state_q == REQ_D);
    assign ps2d_oe      = (state_q == REQ_D) || (state_q == START) ||
                          (((state_q == DATA) || (state_q == STOP)) && !bit_q);
    assign tx_idle      = (state_q == IDLE);
    assign tx_done_tick = (state_q == DONE);
    assign tx_err       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model on open-drain wires, with a scoreboard
// of expected completion results checked whenever tx_done_tick fires.
module tb_ps2_tx;

    localparam int RTS   = 1000;
    localparam int SETUP = 100;
    localparam int TO    = 2000;
    localparam int FL    = 8;
    localparam int HALF  = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_ack_low = 1'b0;
    logic       ps2c_w, ps2d_w;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    bit exp_err_q[$];
    bit e_pop;

    assign ps2c_w = ~(ps2c_oe | dev_clk_low);
    assign ps2d_w = ~(ps2d_oe | dev_ack_low);

    always #5 clk = ~clk;

    ps2_tx #(
        .RTS_CYCLES    (RTS),
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c_in     (ps2c_w),
        .ps2d_in     (ps2d_w),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (tx_done_tick) begin
            done_cnt++;
            if (exp_err_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e_pop = exp_err_q.pop_front();
                chk("tx_err", int'(tx_err), int'(e_pop));
            end
        end
    end

    // Issue a request and measure the RTS and setup phases; returns in the first START cycle.
    task automatic start_xfer(input logic [7:0] b, input bit push, input bit exp_e);
        int t;
        if (push) exp_err_q.push_back(exp_e);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = ~b;
        chk("req_idle", int'(tx_idle), 0);
        t = 0;
        while (ps2c_oe && !ps2d_oe && t < RTS + 10) begin
            t++;
            @(negedge clk);
        end
        chk("rts_cycles", t, RTS);
        t = 0;
        while (ps2c_oe && ps2d_oe && t < SETUP + 10) begin
            t++;
            @(negedge clk);
        end
        chk("setup_cycles", t, SETUP);
        chk("start_oe", int'({ps2c_oe, ps2d_oe}), 1);
    endtask

    task automatic device_clock(input logic [9:0] exp_bits, input int nedges,
                                input bit do_ack, input bit chk_bits, input bit inject);
        repeat (50) @(negedge clk);
        if (chk_bits) chk("start_bit", int'(ps2d_w), 0);
        for (int k = 1; k <= nedges; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k == 11) begin
                dev_ack_low = 1'b0;
                return;
            end
            if (chk_bits && k <= 10)
                chk($sformatf("frame_bit%0d", k - 1), int'(ps2d_w), int'(exp_bits[k-1]));
            if (k == 10 && do_ack) dev_ack_low = 1'b1;
            if (inject && k == 4) begin
                din    = 8'h55;
                wr_ps2 = 1'b1;
                repeat (3) @(negedge clk);
                wr_ps2 = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!tx_done_tick && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", int'(tx_done_tick), 1);
        @(negedge clk);
        chk("idle_after_done", int'(tx_idle), 1);
        chk("oe_after_done", int'({ps2c_oe, ps2d_oe}), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [9:0] fr;
        int t;

        repeat (3) @(negedge clk);
        chk("rst_oe", int'({ps2c_oe, ps2d_oe}), 0);
        chk("rst_idle", int'(tx_idle), 1);
        chk("rst_done", int'(tx_done_tick), 0);
        chk("rst_err", int'(tx_err), 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // 0xED acked: stop,parity=1,data LSB first
        fr = 10'b1_1_11101101;
        start_xfer(8'hED, 1'b1, 1'b0);
        device_clock(fr, 11, 1'b1, 1'b1, 1'b0);
        wait_done();
        repeat (30) @(negedge clk);

        // 0x07 acked: parity 0
        fr = 10'b1_0_00000111;
        start_xfer(8'h07, 1'b1, 1'b0);
        device_clock(fr, 11, 1'b1, 1'b1, 1'b0);
        wait_done();
        repeat (30) @(negedge clk);

        // 0xFF with device NACK
        fr = 10'b1_1_11111111;
        start_xfer(8'hFF, 1'b1, 1'b1);
        device_clock(fr, 11, 1'b0, 1'b1, 1'b0);
        wait_done();
        repeat (30) @(negedge clk);

        // silent device: watchdog abort
        start_xfer(8'hA3, 1'b1, 1'b1);
        t = 0;
        while ((ps2c_oe || ps2d_oe) && t < TO + 50) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_cycles", t, TO);
        wait_done();
        repeat (30) @(negedge clk);

        // 0xF4 with a stray 0x55 request during DATA
        base = done_cnt;
        fr = 10'b1_0_11110100;
        start_xfer(8'hF4, 1'b1, 1'b0);
        device_clock(fr, 11, 1'b1, 1'b1, 1'b1);
        wait_done();
        repeat (200) @(negedge clk);
        chk("single_done", done_cnt - base, 1);
        chk("still_idle", int'(tx_idle), 1);

        // reset in the middle of DATA
        base = done_cnt;
        start_xfer(8'h3C, 1'b0, 1'b0);
        device_clock(10'd0, 3, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_busy", int'(tx_idle), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_oe", int'({ps2c_oe, ps2d_oe}), 0);
        chk("midrst_idle", int'(tx_idle), 1);
        chk("midrst_done", int'(tx_done_tick), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        chk("no_done_after_rst", done_cnt - base, 0);
        chk("scoreboard_empty", exp_err_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
